note_tone_gen: RTL and testbench

Square-wave tone generator that turns the 4-bit note code stream from the song sequencers (auto-play and keyboard modes) into the speaker drive signal. It samples the note code on every quarter-beat edge and plays the matching pitch with glitch-free transitions. A short silent gap separates two different consecutive pitches, while repeated codes sustain. It sits between the note sequencers and the Pmod speaker pin, in the 100 MHz system clock domain.

---
 rtl/note_tone_gen_if.sv | 20 ++
 rtl/note_tone_gen.sv | 136 +++++++++++++
 tb/tb_note_tone_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/note_tone_gen_if.sv
// Note-code, beat and speaker signal bundle between the song sequencers and
// the tone generator.
interface note_tone_gen_if;
    logic       quarter_beat;
    logic [3:0] note;
    logic       enable;
    logic       speaker;
    logic       playing;
    logic [3:0] cur_note;

    modport master (
        output quarter_beat, note, enable,
        input  speaker, playing, cur_note
    );

    modport slave (
        input  quarter_beat, note, enable,
        output speaker, playing, cur_note
    );
endinterface

// File: rtl/note_tone_gen.sv
// Square-wave tone generator: samples the note code on each quarter-beat rise
// and drives the speaker, with a silent gap between two different pitches.
module note_tone_gen #(
    parameter int unsigned     GAP_CYCLES = 500000,
    parameter logic [8*18-1:0] HALF_TABLE = {18'd191110, 18'd170265, 18'd151685, 18'd143172,
                                             18'd127551, 18'd113636, 18'd101239, 18'd95557}
) (
    input  logic            clk_i,
    input  logic            rst_i,
    note_tone_gen_if.slave  bus
);
    // state | meaning
    // IDLE  | silent, no pitch selected, cur_note = 8
    // TONE  | square wave at HALF[cur] cycles per half period
    // GAP   | silent articulation gap before the pending pitch
    typedef enum logic [1:0] {ST_IDLE, ST_TONE, ST_GAP} state_t;

    localparam int GCNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GCNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GCNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [3:0] NOTE_NONE = 4'd8;

    function automatic logic [17:0] half_m1(input logic [2:0] code);
        return HALF_TABLE[int'(code)*18 +: 18] - 18'd1;
    endfunction

    state_t              state_q, state_d;
    logic [17:0]         cnt_q, cnt_d;
    logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
    logic                ph_q, ph_d;
    logic [3:0]          cur_q, cur_d;
    logic [2:0]          sync_q;
    logic                beat_rise;
    logic                note_valid;

    // sync_q[0..2] = b1..b3; the beat is asynchronous to clk_i
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], bus.quarter_beat};
        end
    end

    assign beat_rise  = sync_q[1] & ~sync_q[2];
    assign note_valid = ~bus.note[3];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            ph_q    <= 1'b0;
            cur_q   <= NOTE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            ph_q    <= ph_d;
            cur_q   <= cur_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        ph_d    = ph_q;
        cur_d   = cur_q;
        case (state_q)
            ST_IDLE: begin
                ph_d  = 1'b0;
                cur_d = NOTE_NONE;
                if (beat_rise && note_valid) begin
                    state_d = ST_TONE;
                    cur_d   = bus.note;
                    ph_d    = 1'b1;
                    cnt_d   = half_m1(bus.note[2:0]);
                end
            end
            ST_TONE: begin
                // A repeated code falls through to the free-running toggle path.
                if (beat_rise && (bus.note != cur_q)) begin
                    if (!note_valid) begin
                        state_d = ST_IDLE;
                        ph_d    = 1'b0;
                        cur_d   = NOTE_NONE;
                        cnt_d   = '0;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                        ph_d    = 1'b0;
                        cur_d   = bus.note;
                        gcnt_d  = GAP_LOAD;
                        cnt_d   = '0;
                    end else begin
                        cur_d   = bus.note;
                        ph_d    = 1'b1;
                        cnt_d   = half_m1(bus.note[2:0]);
                    end
                end else if (cnt_q == '0) begin
                    ph_d  = ~ph_q;
                    cnt_d = half_m1(cur_q[2:0]);
                end else begin
                    cnt_d = cnt_q - 18'd1;
                end
            end
            ST_GAP: begin
                ph_d = 1'b0;
                if (beat_rise && !note_valid) begin
                    state_d = ST_IDLE;
                    cur_d   = NOTE_NONE;
                end else begin
                    if (beat_rise) begin
                        cur_d = bus.note;
                    end
                    if (gcnt_q == '0) begin
                        state_d = ST_TONE;
                        ph_d    = 1'b1;
                        cnt_d   = half_m1(cur_d[2:0]);
                    end else begin
                        gcnt_d = gcnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                ph_d    = 1'b0;
                cur_d   = NOTE_NONE;
            end
        endcase
    end

    assign bus.speaker  = ph_q & bus.enable;
    assign bus.playing  = (state_q != ST_IDLE);
    assign bus.cur_note = cur_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed plus randomized bench for note_tone_gen, using shortened pitch and
// gap constants so whole waveforms fit in a short run.
module tb_note_tone_gen;
    localparam int GAP = 23;
    int half_tab [8] = '{29, 31, 37, 41, 43, 47, 53, 61};

    logic clk;
    logic rst;
    note_tone_gen_if bus();

    note_tone_gen #(
        .GAP_CYCLES(GAP),
        .HALF_TABLE({18'd61, 18'd53, 18'd47, 18'd43, 18'd41, 18'd37, 18'd31, 18'd29})
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    // Reference: the generator seen as "which pitch started at which cycle"
    int m_state = 0;   // 0 idle, 1 tone, 2 gap
    int m_cur   = 8;
    int m_t0    = 0;
    int m_gend  = 0;
    bit h1 = 0, h2 = 0, h3 = 0;

    task automatic model_edge();
        int n;
        bit act;
        if (rst) begin
            m_state = 0; m_cur = 8;
            h1 = 0; h2 = 0; h3 = 0;
        end else begin
            act = h2 && !h3;
            n = int'(bus.note);
            if (act) begin
                case (m_state)
                    0: if (n < 8) begin m_state = 1; m_cur = n; m_t0 = cyc; end
                    1: if (n != m_cur) begin
                           if (n >= 8) begin m_state = 0; m_cur = 8; end
                           else begin m_state = 2; m_cur = n; m_gend = cyc + GAP; end
                       end
                    default: if (n >= 8) begin m_state = 0; m_cur = 8; end
                             else m_cur = n;
                endcase
            end
            if (m_state == 2 && cyc == m_gend) begin
                m_state = 1; m_t0 = cyc;
            end
            h3 = h2; h2 = h1; h1 = bus.quarter_beat;
        end
    endtask

    task automatic check();
        logic       exp_spk;
        logic       exp_play;
        logic [3:0] exp_cur;
        exp_spk = 1'b0;
        if (m_state == 1 && bus.enable)
            exp_spk = (((cyc - m_t0) / half_tab[m_cur]) % 2) == 0;
        exp_play = (m_state != 0);
        exp_cur  = 4'(m_cur);
        vectors++;
        assert (bus.speaker === exp_spk) else begin
            miscompares++;
            $error("FAIL speaker cyc=%0d got %b expected %b", cyc, bus.speaker, exp_spk);
        end
        vectors++;
        assert (bus.playing === exp_play) else begin
            miscompares++;
            $error("FAIL playing cyc=%0d got %b expected %b", cyc, bus.playing, exp_play);
        end
        vectors++;
        assert (bus.cur_note === exp_cur) else begin
            miscompares++;
            $error("FAIL cur_note cyc=%0d got %0d expected %0d", cyc, bus.cur_note, exp_cur);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #2;
        check();
    endtask

    task automatic run(input int k);
        repeat (k) step();
    endtask

    task automatic beat(input logic [3:0] n, input int hi, input int lo);
        bus.note = n;
        bus.quarter_beat = 1'b1;
        run(hi);
        bus.quarter_beat = 1'b0;
        run(lo);
    endtask

    initial begin
        bus.quarter_beat = 1'b0;
        bus.note = 4'd8;
        bus.enable = 1'b1;
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        run(2);

        // A tone, then a different pitch through the gap, then sustained repeats
        beat(4'd2, 3, 3);
        run(200);
        beat(4'd3, 3, 3);
        run(120);
        repeat (3) begin
            beat(4'd3, 4, 30);
        end

        // Release to idle with the "none" code and with an invalid code
        beat(4'd8, 3, 10);
        beat(4'd9, 3, 10);
        beat(4'd2, 3, 60);
        beat(4'd12, 3, 10);

        // Reset mid-tone and mid-gap, then C4
        beat(4'd5, 3, 40);
        rst = 1'b1; run(1); rst = 1'b0;
        beat(4'd7, 3, 150);
        beat(4'd4, 3, 5);
        rst = 1'b1; run(1); rst = 1'b0;
        run(3);
        beat(4'd7, 3, 130);

        // Beats during a gap: retarget the pending pitch, then abort it
        beat(4'd1, 3, 3);
        beat(4'd6, 3, 4);
        run(60);
        beat(4'd0, 3, 3);
        beat(4'd15, 3, 40);

        // Mute and unmute while C5 plays
        beat(4'd0, 3, 20);
        bus.enable = 1'b0;
        run(75);
        bus.enable = 1'b1;
        run(80);

        // Beat already high when reset releases
        bus.note = 4'd6;
        bus.quarter_beat = 1'b1;
        rst = 1'b1; run(2); rst = 1'b0;
        run(4);
        bus.quarter_beat = 1'b0;
        run(60);

        for (int i = 0; i < 80; i++) begin
            logic [3:0] n;
            n = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) bus.enable = ~bus.enable;
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1; run(1); rst = 1'b0;
            end
            beat(n, $urandom_range(2, 6), $urandom_range(2, 90));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
